// File: rtl/seq_101_frame_tx_pkg.sv
// seq_frame_pkg: state encoding, default sync pattern and sizing helper for the 101 frame transmitter
package seq_frame_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_GAP    = 3'd4
   } state_t;
   localparam int DEF_SYNC_W = 3;
   localparam logic [DEF_SYNC_W-1:0] DEF_SYNC = 3'b101;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/seq_101_frame_tx_if.sv
// seq_101_frame_tx_if: word handshake (tx_data/tx_valid/tx_ready), bit strobe and serial line status
//   master: producer side, drives tx_data, tx_valid, bit_en
//   slave:  transmitter side, drives tx_ready, data_out, busy, frame_done
interface seq_101_frame_tx_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   logic bit_en;
   logic data_out;
   logic busy;
   logic frame_done;
   modport master (output tx_data, tx_valid, bit_en, input tx_ready, data_out, busy, frame_done);
   modport slave (input tx_data, tx_valid, bit_en, output tx_ready, data_out, busy, frame_done);
endinterface

// File: rtl/seq_101_frame_tx_piso.sv
// piso_shift_reg: parallel-load, shift-left register exposing its MSB
//   clk, rst: clock and sync active-high reset
//   load/din: parallel load (wins over shift); shift: move left by one; msb: current top bit
module piso_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);
   logic [W-1:0] sr_q, sr_d;
   always_comb sr_d = load ? din : shift ? sr_q << 1 : sr_q;
   always_ff @(posedge clk) sr_q <= rst ? '0 : sr_d;
   assign msb = sr_q[W-1];
endmodule

// File: rtl/seq_101_frame_tx.sv
// seq_101_frame_tx: sends each accepted word as SYNC, DATA (MSB first), even parity, then idle gap bits
//   clk, rst: clock and sync active-high reset
//   tx (slave): tx_data/tx_valid/tx_ready word handshake, bit_en strobe,
//               data_out serial line, busy, frame_done pulse
module seq_101_frame_tx
   import seq_frame_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                SYNC_W   = DEF_SYNC_W,
   parameter logic [SYNC_W-1:0] SYNC     = DEF_SYNC,
   parameter int                GAP_BITS = 2,
   parameter logic              IDLE_BIT = 1'b0
) (
   input logic clk,
   input logic rst,
   seq_101_frame_tx_if.slave tx
);
   localparam int CW = $clog2(max3(SYNC_W, DATA_W, GAP_BITS) + 1);
   state_t st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SYNC_W-1:0] sync_sh;
   logic dout_q, dout_d, par_q, par_d, done_q, done_d;
   logic accept, shift, msb;
   assign accept = tx.tx_valid && st_q == ST_IDLE;
   // next sync bit selected by shift to keep the index width independent of SYNC_W
   assign sync_sh = SYNC >> (cnt_q - 1'b1);
   piso_shift_reg #(.W(DATA_W)) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .shift (shift),
      .din   (tx.tx_data),
      .msb   (msb)
   );
   // the shift register is advanced as each payload bit is launched, so msb is always the next bit
   always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      dout_d = dout_q;
      par_d = par_q;
      done_d = 1'b0;
      shift = 1'b0;
      case (st_q)
         ST_IDLE: begin
            dout_d = accept ? SYNC[SYNC_W-1] : IDLE_BIT;
            st_d = accept ? ST_SYNC : ST_IDLE;
            cnt_d = accept ? CW'(SYNC_W - 1) : '0;
            par_d = accept ? ^tx.tx_data : par_q;
         end
         ST_SYNC: if (tx.bit_en) begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               dout_d = sync_sh[0];
            end else begin
               st_d = ST_DATA;
               cnt_d = CW'(DATA_W - 1);
               dout_d = msb;
               shift = 1'b1;
            end
         end
         ST_DATA: if (tx.bit_en) begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               dout_d = msb;
               shift = 1'b1;
            end else begin
               st_d = ST_PARITY;
               cnt_d = '0;
               dout_d = par_q;
            end
         end
         ST_PARITY: if (tx.bit_en) begin
            st_d = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
            cnt_d = (GAP_BITS > 0) ? CW'(GAP_BITS - 1) : '0;
            dout_d = IDLE_BIT;
            done_d = (GAP_BITS == 0);
         end
         ST_GAP: if (tx.bit_en) begin
            st_d = (cnt_q != '0) ? ST_GAP : ST_IDLE;
            cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
            dout_d = IDLE_BIT;
            done_d = (cnt_q == '0);
         end
         default: begin
            st_d = ST_IDLE;
            cnt_d = '0;
            dout_d = IDLE_BIT;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q <= ST_IDLE;
         cnt_q <= '0;
         dout_q <= IDLE_BIT;
         par_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q <= st_d;
         cnt_q <= cnt_d;
         dout_q <= dout_d;
         par_q <= par_d;
         done_q <= done_d;
      end
   end
   assign tx.tx_ready = st_q == ST_IDLE;
   assign tx.busy = st_q != ST_IDLE;
   assign tx.data_out = dout_q;
   assign tx.frame_done = done_q;
endmodule
